// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan: segment encodings and scan FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} pattern for each hex digit 0..F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment scanner with anode-off ghost gap and per-frame value latching.
module seven_seg_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int GHOST_CYCLES = 2
) (
    input  logic                    clock,
    input  logic                    greset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic                    frame_done
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int GW = (GHOST_CYCLES > 1) ? $clog2(GHOST_CYCLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GHOST_CYCLES > 0) ? GHOST_CYCLES - 1 : 0);

    scan_state_t               state, state_nx;
    logic [IW-1:0]             idx, idx_nx;
    logic [GW-1:0]             gap, gap_nx;
    logic                      cap_pending;
    logic                      wrap;
    logic                      capture;
    logic [4*NUM_DIGITS-1:0]   sh_value, sh_value_nx;
    logic [NUM_DIGITS-1:0]     sh_dp, sh_dp_nx;
    logic [NUM_DIGITS-1:0]     sh_blank, sh_blank_nx;
    logic [3:0]                nib;
    logic                      dp_bit;
    logic                      blank_bit;
    logic [6:0]                dec_seg;
    logic [NUM_DIGITS-1:0]     an_nx;
    logic [6:0]                seg_nx;
    logic                      dp_n_nx;

    hex_to_seg7 u_dec (
        .hex (nib),
        .seg (dec_seg)
    );

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        gap_nx   = gap;
        wrap     = 1'b0;

        unique case (state)
            BLANK: begin
                if (GHOST_CYCLES == 0 || gap == GAP_LAST) begin
                    state_nx = SHOW;
                    gap_nx   = '0;
                end else begin
                    gap_nx = gap + 1'b1;
                end
            end
            SHOW: begin
                if (enable) begin
                    wrap     = (idx == LAST_IDX);
                    idx_nx   = wrap ? '0 : idx + 1'b1;
                    state_nx = (GHOST_CYCLES == 0) ? SHOW : BLANK;
                    gap_nx   = '0;
                end
            end
            default: state_nx = BLANK;
        endcase

        capture     = cap_pending || wrap;
        sh_value_nx = capture ? value      : sh_value;
        sh_dp_nx    = capture ? dp_in      : sh_dp;
        sh_blank_nx = capture ? blank_mask : sh_blank;

        // Outputs are registered from next-cycle state so the freshly latched frame shows at once
        nib       = '0;
        dp_bit    = 1'b0;
        blank_bit = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nx == IW'(i)) begin
                nib       = sh_value_nx[4*i +: 4];
                dp_bit    = sh_dp_nx[i];
                blank_bit = sh_blank_nx[i];
            end
        end

        an_nx   = '1;
        seg_nx  = SEG_OFF;
        dp_n_nx = 1'b1;
        if (state_nx == SHOW && !blank_bit) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (idx_nx == IW'(i)) an_nx[i] = 1'b0;
            end
            seg_nx  = dec_seg;
            dp_n_nx = ~dp_bit;
        end
    end

    always_ff @(posedge clock) begin
        if (greset) begin
            state       <= BLANK;
            idx         <= '0;
            gap         <= '0;
            cap_pending <= 1'b1;
            sh_value    <= '0;
            sh_dp       <= '0;
            sh_blank    <= '0;
            an          <= '1;
            seg         <= SEG_OFF;
            dp_n        <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            gap         <= gap_nx;
            cap_pending <= 1'b0;
            sh_value    <= sh_value_nx;
            sh_dp       <= sh_dp_nx;
            sh_blank    <= sh_blank_nx;
            an          <= an_nx;
            seg         <= seg_nx;
            dp_n        <= dp_n_nx;
            frame_done  <= wrap;
        end
    end

endmodule
